// File: rtl/muxn_rr_if.sv
// Stream bundle between N producers, the muxn_rr arbiter and one consumer.
// The slave modport is the multiplexer side; master is the surrounding environment.
interface muxn_rr_if #(
  parameter int W = 4,
  parameter int N = 4
);
  localparam int CW = $clog2(N);

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_ch;
  logic           out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/muxn_rr.sv
// N-channel registered stream multiplexer with round-robin (RR=1) or
// lowest-index-first (RR=0) arbitration into a single output register.
module muxn_rr #(
  parameter int W  = 4,
  parameter int N  = 4,
  parameter int RR = 1
) (
  input  logic      clk,
  input  logic      rst,
  muxn_rr_if.slave  bus
);
  localparam int CW = $clog2(N);

  logic          r_outValid;
  logic [W-1:0]  r_outData;
  logic [CW-1:0] r_outCh;
  logic [CW-1:0] r_ptr;

  logic          w_load;
  logic          w_any;
  logic [CW-1:0] w_start;
  logic [CW:0]   w_cand;
  logic [CW-1:0] w_gIdx;
  logic [N-1:0]  w_grant;
  logic [W-1:0]  w_gData;
  logic [CW-1:0] w_ptrNext;

  assign w_load  = !r_outValid || bus.out_ready;
  assign w_start = (RR != 0) ? r_ptr : '0;

  // Scan upward from the start channel with explicit wrap so any N works.
  always_comb begin
    w_any  = 1'b0;
    w_gIdx = '0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, w_start} + (CW+1)'(k);
      if (w_cand >= (CW+1)'(N))
        w_cand = w_cand - (CW+1)'(N);
      if (!w_any && bus.in_valid[w_cand[CW-1:0]]) begin
        w_any  = 1'b1;
        w_gIdx = w_cand[CW-1:0];
      end
    end
  end

  always_comb begin
    w_grant = '0;
    w_gData = '0;
    if (w_any)
      w_grant[w_gIdx] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (w_gIdx == CW'(i))
        w_gData = bus.in_data[i*W +: W];
    end
  end

  assign w_ptrNext = (w_gIdx == CW'(N-1)) ? '0 : w_gIdx + CW'(1);

  // Reset suppresses ready so no source believes a word was taken.
  assign bus.in_ready  = w_grant & {N{w_load && !rst}};
  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_outData;
  assign bus.out_ch    = r_outCh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outCh    <= '0;
      r_ptr      <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_outValid <= 1'b1;
        r_outData  <= w_gData;
        r_outCh    <= w_gIdx;
        if (RR != 0)
          r_ptr <= w_ptrNext;
      end else begin
        r_outValid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/muxn_rr.md
# muxn_rr

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshakes and round-robin or fixed-priority arbitration. It generalises the 4:1 4-bit combinational mux so that several producers can share one downstream datapath without a software-driven select. It sits between N independent sources and a single consumer.

## Interface
- `W`, default 4: data width per channel, ≥1.
- `N`, default 4: number of input channels, ≥2.
- `RR`, default 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- `CW`, default `$clog2(N)`: channel-index width; localparam, not overridable.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  N  bit i: channel i presents data.
- `in_data`  in  N*W  channel i at `[i*W +: W]`.
- `in_ready`  out  N  bit i: channel i's word is accepted this cycle.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  W  registered data.
- `out_ch`  out  CW  index of the channel that produced `out_data`.
- `out_ready`  in  1  consumer accepts the word this cycle.

## Operation
- **Transfers.** An input transfer occurs on channel i when `in_valid[i] && in_ready[i]`. An output transfer occurs when `out_valid && out_ready`.
- **Load condition.** `load = !out_valid || out_ready`. The output register can take a new word this cycle.
- **Grant.** Combinational, one-hot or zero:
  - RR=1: the first valid channel searching upward from pointer `ptr`, wrapping N-1→0.
  - RR=0: the lowest-index valid channel.
- **Ready.** `in_ready = grant & {N{load}}`. At most one bit is set. `in_ready` is asserted even if the consumer has not yet drained, provided `out_ready` is high that cycle.
- **On a load with a grant to channel g:**
  - `out_data <= in_data[g]`, `out_ch <= g`, `out_valid <= 1`.
  - If RR=1, `ptr <= (g+1) mod N`. Wrap is explicit, so non-power-of-2 N is legal.
- **On a load with no valid input:** `out_valid <= 0`. `out_data` and `out_ch` hold their values.
- **No load (stall):** `out_valid`, `out_data`, `out_ch` and `ptr` all hold. Sources must keep `in_valid` and `in_data` stable until accepted; the block does not check this.
- **Pointer.** `ptr` moves only on an accepted input. It does not move while idle or stalled.
- **Fairness.** With all channels continuously valid and `out_ready`=1, RR=1 grants 0,1,…,N-1,0,… . RR=0 grants channel 0 forever (starvation is by design).
- **Paths.** No combinational path from `in_data` to `out_data`. There is a combinational path from `in_valid`/`out_ready` to `in_ready`.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0, hence `in_ready`=0 during reset.
- **Reset mid-operation:** a word held in the output register is discarded. On the first cycle after `rst` deasserts, arbitration restarts with channel 0 first.
- **Latency:** 1 cycle. A word accepted at edge k is visible on `out_*` after edge k.
- **Throughput:** 1 word/cycle when `out_ready` is held high.
- **Simultaneous drain and fill:** with `out_valid`=1 and `out_ready`=1, the old word leaves and the new word loads on the same edge. There is no bubble.
- **Backpressure:** with `out_ready`=0 and `out_valid`=1, all `in_ready` bits are 0. The output word is held unchanged until it is accepted.

## Test plan
1. **Reset.** Assert `rst` for 3 cycles with all `in_valid`=1 → `in_ready`=0000, `out_valid`=0, `out_data`=0, `out_ch`=0 during reset. The first grant after reset goes to ch0.
2. **Round-robin sweep.** RR=1, N=4, W=4, `in_data` = {D,C,B,A} (ch3..ch0), all valid, `out_ready`=1 → the output sequence is A/0, B/1, C/2, D/3, A/0, one word per cycle, with no gaps.
3. **Sparse requests and wrap.** RR=1. Only ch1 and ch3 valid → alternate 1,3,1,3. Then drop ch3 → ch1 every cycle. `ptr` wraps 3→0 correctly.
4. **Backpressure.** Word 0x5 from ch2 is loaded, then `out_ready`=0 for 4 cycles → `out_valid`=1, `out_data`=0x5 and `out_ch`=2 stable, `in_ready`=0000. Raise `out_ready` → 0x5 drains and the next grant loads on the same edge.
5. **Fixed priority.** RR=0, all valid → ch0 is granted every cycle. Deassert ch0 → ch1 is granted. ch3 is granted only when ch0–ch2 are all idle.
6. **Non-power-of-2 and reset mid-stream.** N=3, RR=1, all valid → the grant sequence is 0,1,2,0. Assert `rst` with `out_valid`=1 → the word is dropped, and the next grant is ch0.
